// File: rtl/demux_1x16_if.sv
// demux_1x16_if: routing bus between a data source and the 1-to-16 demux
interface demux_1x16_if #(parameter int DATA_W = 1);
  logic [DATA_W-1:0] in;
  logic [3:0] sel;
  logic en;
  logic [16*DATA_W-1:0] out;
  logic out_valid;
  logic [3:0] sel_q;
  modport master(output in, sel, en, input out, out_valid, sel_q);
  modport slave(input in, sel, en, output out, out_valid, sel_q);
endinterface

// File: rtl/demux_1x16.sv
// demux_1x16: registered 1-to-16 lane demultiplexer, one-cycle latency
module demux_1x16 #(parameter int DATA_W = 1) (
  input logic clk,
  input logic rst,
  demux_1x16_if.slave bus
);
  logic [16*DATA_W-1:0] route;
  always_comb route = bus.en ? ({{(15*DATA_W){1'b0}}, bus.in} << (bus.sel * DATA_W)) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      bus.out <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_q <= 4'd0;
    end else begin
      bus.out <= route;
      bus.out_valid <= bus.en;
      if (bus.en) bus.sel_q <= bus.sel;
    end
endmodule

// File: tb/tb_demux_1x16.sv
// tb_demux_1x16: scoreboard bench for the narrow and 8-bit demux variants
module tb_demux_1x16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  demux_1x16_if #(.DATA_W(1)) nb();
  demux_1x16_if #(.DATA_W(8)) wb();
  demux_1x16 #(.DATA_W(1)) dn(.clk(clk), .rst(rst), .bus(nb));
  demux_1x16 #(.DATA_W(8)) dw(.clk(clk), .rst(rst), .bus(wb));
  typedef struct packed {
    logic [15:0] o;
    logic v;
    logic [3:0] s;
  } exp_t;
  exp_t q[$];
  exp_t x;
  logic [3:0] m_sq = 4'd0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input logic r, input logic e, input logic i, input logic [3:0] s);
    exp_t t;
    rst = r;
    nb.en = e;
    nb.in = i;
    nb.sel = s;
    if (r) begin
      t = '{16'h0, 1'b0, 4'd0};
      m_sq = 4'd0;
    end else if (e) begin
      t = '{(i ? 16'h1 << s : 16'h0), 1'b1, s};
      m_sq = s;
    end else
      t = '{16'h0, 1'b0, m_sq};
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b1, 4'd5);
      x = q.pop_front();
      n_cmp++;
      if ({nb.out, nb.out_valid, nb.sel_q} !== x) begin
        n_bad++;
        $display("FAIL reset[%0d]: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", k, nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
      end
    end
  endtask

  task automatic test_sweep;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b1, 4'(k));
      x = q.pop_front();
      n_cmp++;
      if ({nb.out, nb.out_valid, nb.sel_q} !== x || nb.out !== 16'h1 << k) begin
        n_bad++;
        $display("FAIL sweep[%0d]: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", k, nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
      end
    end
  endtask

  task automatic test_zero_data;
    drive(1'b0, 1'b1, 1'b0, 4'd3);
    x = q.pop_front();
    n_cmp++;
    if ({nb.out, nb.out_valid, nb.sel_q} !== x || nb.out_valid !== 1'b1 || nb.sel_q !== 4'd3) begin
      n_bad++;
      $display("FAIL zero_data: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
    end
  endtask

  task automatic test_disable;
    drive(1'b0, 1'b1, 1'b1, 4'd7);
    drive(1'b0, 1'b0, 1'b1, 4'd2);
    for (int k = 0; k < 2; k++) begin
      x = q.pop_front();
      if (k == 1) begin
        n_cmp++;
        if ({nb.out, nb.out_valid, nb.sel_q} !== x || nb.sel_q !== 4'd7) begin
          n_bad++;
          $display("FAIL disable: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    x = q.pop_front();
    n_cmp++;
    if (nb.out !== 16'h0200) begin
      n_bad++;
      $display("FAIL stream_pre: got out=%h want out=0200", nb.out);
    end
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({nb.out, nb.out_valid, nb.sel_q} !== x) begin
      n_bad++;
      $display("FAIL sync_rst_hold: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd9);
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    for (int k = 0; k < 2; k++) begin
      x = q.pop_front();
      n_cmp++;
      if (x.o !== (k == 0 ? 16'h0 : 16'h0200)) begin
        n_bad++;
        $display("FAIL stream_model[%0d]: got out=%h", k, x.o);
      end
    end
    n_cmp++;
    if ({nb.out, nb.out_valid, nb.sel_q} !== x) begin
      n_bad++;
      $display("FAIL stream_post: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] s;
    logic e;
    for (int k = 0; k < 40; k++) begin
      s = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      drive(1'b0, e, 1'b1, s);
      x = q.pop_front();
      n_cmp++;
      if ({nb.out, nb.out_valid, nb.sel_q} !== x || $countones(nb.out) > 1) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got out=%h v=%b sq=%0d want out=%h v=%b sq=%0d", k, nb.out, nb.out_valid, nb.sel_q, x.o, x.v, x.s);
      end
    end
  endtask

  task automatic test_wide;
    logic [127:0] w;
    w = 128'hA5 << 16;
    wb.en = 1'b1;
    wb.in = 8'hA5;
    wb.sel = 4'd2;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    x = q.pop_front();
    n_cmp++;
    if (wb.out !== w || wb.out_valid !== 1'b1 || wb.sel_q !== 4'd2) begin
      n_bad++;
      $display("FAIL wide: got out=%h v=%b sq=%0d want out=%h v=1 sq=2", wb.out, wb.out_valid, wb.sel_q, w);
    end
    wb.sel = 4'd15;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    x = q.pop_front();
    w = 128'hA5 << 120;
    n_cmp++;
    if (wb.out !== w) begin
      n_bad++;
      $display("FAIL wide_msb: got out=%h want out=%h", wb.out, w);
    end
    wb.en = 1'b0;
  endtask

  initial begin
    nb.en = 1'b0;
    nb.in = 1'b0;
    nb.sel = 4'd0;
    wb.en = 1'b0;
    wb.in = 8'h0;
    wb.sel = 4'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_zero_data();
    test_disable();
    test_reset_midstream();
    test_back_to_back();
    test_wide();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
